// File: rtl/i2c_ctrl_pkg.sv
// Shared types and constants for the camera-control I2C register access path.
// Used by the bus arbiter and by the config sequencer.
package i2c_ctrl_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    typedef struct packed {
        logic        rnw;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } reg_access_t;

    localparam logic [7:0]  DEV_ADDR_DEFAULT = 8'hC0;
    localparam logic [7:0]  NUM_BYTES_WR     = 8'd3;
    localparam logic [7:0]  NUM_BYTES_RD     = 8'd1;
    localparam int unsigned RETRY_MAX        = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot picker: the first requester after the stored pointer wins.
// The pointer loads the index of upd_gnt when upd_en is high.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         upd_en,
    input  logic [N-1:0] upd_gnt,
    output logic [N-1:0] pick
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] upd_idx;

    always_comb begin
        pick = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            if (pick == '0 && req[(32'(ptr) + i) % N])
                pick[(32'(ptr) + i) % N] = 1'b1;
        end
    end

    always_comb begin
        upd_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (upd_gnt[k])
                upd_idx = PW'(k);
        end
    end

    // Reset to the last index so client 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= PW'(N - 1);
        else if (upd_en)
            ptr <= upd_idx;
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin sharing of one I2C master between NUM_REQ register-access clients.
// Optional macro I2C_ARB_RETRY_EN: re-issue a NACKed transaction up to two more times.
module i2c_bus_arbiter
    import i2c_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter logic [7:0]  DEV_ADDR    = DEV_ADDR_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_REQ-1:0]      i_req,
    input  logic [NUM_REQ-1:0]      i_rnw,
    input  logic [NUM_REQ*16-1:0]   i_addr,
    input  logic [NUM_REQ*8-1:0]    i_wdata,
    output logic [NUM_REQ-1:0]      o_gnt,
    output logic [NUM_REQ-1:0]      o_ack,
    output logic                    o_err,
    output logic [7:0]              o_rdata,
    output logic [7:0]              o_i2c_slave_addr,
    output logic [7:0]              o_mst_command_byte,
    output logic [7:0]              o_mst_num_bytes,
    output logic [DATA_WIDTH-1:0]   o_mst_din,
    output logic                    o_mst_write,
    output logic                    o_mst_read,
    output logic                    o_i2c_soft_rst,
    output logic                    o_i2c_arb_lost_clr,
    input  logic                    i_i2c_busy,
    input  logic                    i_mst_write_done,
    input  logic                    i_mst_data_out_valid,
    input  logic [DATA_WIDTH-1:0]   i_mst_data_out,
    input  logic                    i_i2c_rxak,
    input  logic                    i_i2c_arb_lost
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] gnt, pick;
    reg_access_t        xact, xact_sel;
    logic [CW-1:0]      to_cnt;
    logic [7:0]         rdata_q;
    logic               rd_seen, err_q, arb_q, to_q;
    logic               active, done, to_hit, retry;
    logic               unused_bits;
`ifdef I2C_ARB_RETRY_EN
    logic [1:0]         tries;
`endif

    assign unused_bits = ^i_mst_data_out[DATA_WIDTH-1:8];

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (i_clk),
        .rst     (i_rst),
        .req     (i_req),
        .upd_en  (state == ARB_RESP),
        .upd_gnt (gnt),
        .pick    (pick)
    );

    always_comb begin
        xact_sel = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick[k])
                xact_sel = '{rnw: i_rnw[k], addr: i_addr[16*k +: 16], wdata: i_wdata[8*k +: 8]};
        end
    end

    always_comb begin
        active = (state == ARB_ISSUE) || (state == ARB_WAIT);
        to_hit = active && (to_cnt == CW'(TIMEOUT_CYC - 1));
        done   = (state == ARB_WAIT) && !i_i2c_busy &&
                 (xact.rnw ? (rd_seen || i_mst_data_out_valid) : i_mst_write_done);
`ifdef I2C_ARB_RETRY_EN
        retry  = done && i_i2c_rxak && !i_i2c_arb_lost && (tries < 2'(RETRY_MAX));
`else
        retry  = 1'b0;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (|i_req) state_nxt = ARB_ISSUE;
            ARB_ISSUE: begin
                if (to_hit)          state_nxt = ARB_RESP;
                else if (i_i2c_busy) state_nxt = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (to_hit)          state_nxt = ARB_RESP;
                else if (retry)      state_nxt = ARB_ISSUE;
                else if (done)       state_nxt = ARB_RESP;
            end
            ARB_RESP:  state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gnt     <= '0;
            xact    <= '0;
            to_cnt  <= '0;
            rdata_q <= '0;
            rd_seen <= 1'b0;
            err_q   <= 1'b0;
            arb_q   <= 1'b0;
            to_q    <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
            tries   <= '0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|i_req) begin
                        gnt     <= pick;
                        xact    <= xact_sel;
                        to_cnt  <= '0;
                        rdata_q <= '0;
                        rd_seen <= 1'b0;
                        err_q   <= 1'b0;
                        arb_q   <= 1'b0;
                        to_q    <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
                        tries   <= '0;
`endif
                    end
                end
                ARB_ISSUE, ARB_WAIT: begin
                    to_cnt <= to_cnt + CW'(1);
                    if (state == ARB_WAIT && i_mst_data_out_valid) begin
                        rdata_q <= i_mst_data_out[7:0];
                        rd_seen <= 1'b1;
                    end
                    // Timeout overrides any completion seen in the same cycle.
                    if (to_hit) begin
                        err_q   <= 1'b1;
                        to_q    <= 1'b1;
                        rdata_q <= '0;
                    end else if (retry) begin
                        to_cnt  <= '0;
                        rd_seen <= 1'b0;
`ifdef I2C_ARB_RETRY_EN
                        tries   <= tries + 2'd1;
`endif
                    end else if (done) begin
                        err_q <= i_i2c_rxak | i_i2c_arb_lost;
                        arb_q <= i_i2c_arb_lost;
                    end
                end
                ARB_RESP: gnt <= '0;
                default:  gnt <= '0;
            endcase
        end
    end

    always_comb begin
        o_gnt              = gnt;
        o_ack              = (state == ARB_RESP) ? gnt : '0;
        o_err              = (state == ARB_RESP) && err_q;
        o_rdata            = (state == ARB_RESP && xact.rnw) ? rdata_q : '0;
        o_i2c_soft_rst     = (state == ARB_RESP) && to_q;
        o_i2c_arb_lost_clr = (state == ARB_RESP) && arb_q;
        o_mst_write        = (state == ARB_ISSUE) && !xact.rnw && !i_i2c_busy;
        o_mst_read         = (state == ARB_ISSUE) &&  xact.rnw && !i_i2c_busy;
        o_i2c_slave_addr   = '0;
        o_mst_command_byte = '0;
        o_mst_num_bytes    = '0;
        o_mst_din          = '0;
        if (active) begin
            o_i2c_slave_addr   = DEV_ADDR | {7'd0, xact.rnw};
            o_mst_command_byte = xact.addr[15:8];
            o_mst_num_bytes    = xact.rnw ? NUM_BYTES_RD : NUM_BYTES_WR;
            o_mst_din          = xact.rnw ? DATA_WIDTH'(xact.addr[7:0])
                                          : DATA_WIDTH'({xact.wdata, xact.addr[7:0]});
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with a small I2C master model.
module tb_i2c_bus_arbiter;

    localparam int NR    = 3;
    localparam int DW    = 32;
    localparam int TO    = 40;
    localparam int LIMIT = 200;
`ifdef I2C_ARB_RETRY_EN
    localparam int NACK_TRIES = 3;
`else
    localparam int NACK_TRIES = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req, rnw;
    logic [NR*16-1:0] addr;
    logic [NR*8-1:0] wdata;
    logic [NR-1:0]   gnt, ack;
    logic            err, mst_write, mst_read, soft_rst, arb_clr;
    logic [7:0]      rdata, slave, cmd, num;
    logic [DW-1:0]   din, dout;
    logic            busy, wdone, dvalid, rxak, arb_lost;

    i2c_bus_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO), .DEV_ADDR(8'hC0)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_rnw(rnw), .i_addr(addr), .i_wdata(wdata),
        .o_gnt(gnt), .o_ack(ack), .o_err(err), .o_rdata(rdata),
        .o_i2c_slave_addr(slave), .o_mst_command_byte(cmd), .o_mst_num_bytes(num),
        .o_mst_din(din), .o_mst_write(mst_write), .o_mst_read(mst_read),
        .o_i2c_soft_rst(soft_rst), .o_i2c_arb_lost_clr(arb_clr),
        .i_i2c_busy(busy), .i_mst_write_done(wdone), .i_mst_data_out_valid(dvalid),
        .i_mst_data_out(dout), .i_i2c_rxak(rxak), .i_i2c_arb_lost(arb_lost)
    );

    always #5 clk = ~clk;

    int total = 0, passes = 0, cyc = 0, ack_total = 0, strobes = 0;
    logic model_en = 1'b0, m_reset = 1'b0, m_nack = 1'b0, m_arb = 1'b0;
    logic [7:0] m_rdval = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (|ack) ack_total++;

    // Master model: busy for a few cycles, then write_done or read data with status.
    initial begin
        int phase = 0, cnt = 0;
        logic is_rd = 1'b0;
        busy = 0; wdone = 0; dvalid = 0; rxak = 0; arb_lost = 0; dout = '0;
        forever begin
            @(negedge clk); #1;
            if (m_reset) begin
                phase = 0; busy = 0; wdone = 0; dvalid = 0; rxak = 0; arb_lost = 0;
            end else begin
                if (phase == 3) begin wdone = 0; rxak = 0; arb_lost = 0; phase = 0; end
                case (phase)
                    0: if (model_en && (mst_write || mst_read)) begin
                        strobes++; is_rd = mst_read; busy = 1; cnt = 0; phase = 1;
                    end
                    1: begin
                        cnt++;
                        if (cnt == 3) begin
                            if (is_rd) begin dvalid = 1; dout = {24'hABCDEF, m_rdval}; end
                            else wdone = 1;
                            rxak = m_nack; arb_lost = m_arb; phase = 2;
                        end
                    end
                    2: begin dvalid = 0; busy = 0; phase = 3; end
                    default: phase = 0;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_gnt(output logic [NR-1:0] g, output int c);
        bit hit = 0;
        g = '0; c = 0;
        for (int i = 0; i < LIMIT && !hit; i++) begin
            @(negedge clk);
            if (gnt != '0) begin g = gnt; c = cyc; hit = 1; end
        end
        if (!hit) begin total++; $display("FAIL wait_gnt: no grant within %0d cycles", LIMIT); end
    endtask

    task automatic wait_ack(output logic [NR-1:0] a, output logic e, output logic [7:0] rd,
                            output logic sr, output logic ac, output int c);
        bit hit = 0;
        a = '0; e = 0; rd = '0; sr = 0; ac = 0; c = 0;
        for (int i = 0; i < LIMIT && !hit; i++) begin
            @(negedge clk);
            if (ack != '0) begin a = ack; e = err; rd = rdata; sr = soft_rst; ac = arb_clr; c = cyc; hit = 1; end
        end
        if (!hit) begin total++; $display("FAIL wait_ack: no ack within %0d cycles", LIMIT); end
    endtask

    typedef struct {
        int client; logic rnw; logic [15:0] addr; logic [7:0] wdata; logic [7:0] rdval;
        logic nack; logic arb;
        logic [7:0] e_slave, e_cmd, e_num; logic [31:0] e_din; logic e_err; logic [7:0] e_rdata; int e_strobes;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [NR-1:0] g, a;
        logic e, sr, ac;
        logic [7:0] rd;
        int c0, c1, a0;
        logic [NR-1:0] fair_exp[4];

        vecs[0] = '{1, 0, 16'h3501, 8'h2A, 8'h00, 0, 0, 8'hC0, 8'h35, 8'd3, 32'h00002A01, 0, 8'h00, 1};
        vecs[1] = '{2, 1, 16'h300A, 8'h00, 8'h92, 0, 0, 8'hC1, 8'h30, 8'd1, 32'h0000000A, 0, 8'h92, 1};
        vecs[2] = '{0, 0, 16'h0100, 8'h01, 8'h00, 1, 0, 8'hC0, 8'h01, 8'd3, 32'h00000100, 1, 8'h00, NACK_TRIES};
        vecs[3] = '{1, 1, 16'h3500, 8'h00, 8'h5A, 0, 0, 8'hC1, 8'h35, 8'd1, 32'h00000000, 0, 8'h5A, 1};
        vecs[4] = '{2, 0, 16'h3212, 8'h77, 8'h00, 0, 1, 8'hC0, 8'h32, 8'd3, 32'h00007712, 1, 8'h00, 1};

        rst = 1; req = '0; rnw = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {ack, gnt, err, rdata, slave, cmd, num, mst_write, mst_read, soft_rst, arb_clr}, '0);
        chk("reset_din", din, '0);
        rst = 0; model_en = 1;

        foreach (vecs[i]) begin
            @(negedge clk);
            rnw[vecs[i].client] = vecs[i].rnw;
            addr[16*vecs[i].client +: 16] = vecs[i].addr;
            wdata[8*vecs[i].client +: 8] = vecs[i].wdata;
            m_nack = vecs[i].nack; m_arb = vecs[i].arb; m_rdval = vecs[i].rdval;
            strobes = 0;
            req[vecs[i].client] = 1'b1;
            wait_gnt(g, c0);
            chk("vec_gnt", g, NR'(1) << vecs[i].client);
            chk("vec_slave", slave, vecs[i].e_slave);
            chk("vec_cmd", cmd, vecs[i].e_cmd);
            chk("vec_num", num, vecs[i].e_num);
            chk("vec_din", din, vecs[i].e_din);
            chk("vec_strobe", {mst_write, mst_read}, vecs[i].rnw ? 2'b01 : 2'b10);
            // Drop the request and scramble the fields; the transaction must still complete.
            req = '0; rnw = ~rnw; addr = '1; wdata = '1;
            wait_ack(a, e, rd, sr, ac, c1);
            chk("vec_ack", a, NR'(1) << vecs[i].client);
            chk("vec_err", e, vecs[i].e_err);
            chk("vec_rdata", rd, vecs[i].e_rdata);
            chk("vec_arbclr_srst", {ac, sr}, {vecs[i].arb, 1'b0});
            repeat (3) @(negedge clk);
            chk("vec_strobes", strobes, vecs[i].e_strobes);
            rnw = '0; m_nack = 0; m_arb = 0;
        end

        // Reset while the master is busy.
        @(negedge clk);
        rnw = '0; req = 3'b100;
        wait_gnt(g, c0);
        @(negedge clk);
        chk("wait_no_strobe", {mst_write, mst_read, ack}, '0);
        a0 = ack_total; rst = 1; m_reset = 1; req = '0;
        @(negedge clk);
        chk("midrst_ctl", {ack, gnt, err, rdata, slave, cmd, num, mst_write, mst_read, soft_rst, arb_clr}, '0);
        chk("midrst_din", din, '0);
        rst = 0; m_reset = 0;
        repeat (3) @(negedge clk);
        chk("midrst_no_ack", ack_total - a0, 0);
        req = 3'b011;
        wait_gnt(g, c0);
        chk("post_rst_gnt", g, 3'b001);
        wait_ack(a, e, rd, sr, ac, c1);
        chk("post_rst_ack", {a, e}, {3'b001, 1'b0});
        req[0] = 0;
        wait_gnt(g, c0);
        chk("post_rst_gnt2", g, 3'b010);
        req = '0;
        wait_ack(a, e, rd, sr, ac, c1);
        chk("post_rst_ack2", a, 3'b010);

        // Timeout: master never goes busy.
        @(negedge clk); rst = 1; @(negedge clk); rst = 0;
        model_en = 0; rnw = 3'b001; addr[15:0] = 16'h0102; req = 3'b011;
        wait_gnt(g, c0);
        chk("to_gnt", g, 3'b001);
        wait_ack(a, e, rd, sr, ac, c1);
        chk("to_ack", a, 3'b001);
        chk("to_err_srst", {e, sr, ac}, 3'b110);
        chk("to_rdata", rd, 8'h00);
        chk("to_cycles", c1 - c0, TO);
        model_en = 1; req[0] = 0;
        wait_gnt(g, c0);
        chk("to_next_gnt", g, 3'b010);
        chk("to_next_gap", c0 - c1, 2);
        req = '0;
        wait_ack(a, e, rd, sr, ac, c1);
        chk("to_next_ack", {a, e, sr}, {3'b010, 2'b00});

        // Fairness with all clients holding their requests from reset.
        @(negedge clk); rst = 1; rnw = '0; @(negedge clk);
        rst = 0; req = 3'b111; a0 = ack_total; c1 = 0;
        fair_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        for (int i = 0; i < 4; i++) begin
            wait_gnt(g, c0);
            chk("fair_gnt", g, fair_exp[i]);
            if (i > 0) chk("fair_gap", c0 - c1, 2);
            wait_ack(a, e, rd, sr, ac, c1);
            chk("fair_ack", a, fair_exp[i]);
            if (i == 3) req = '0;
        end
        repeat (4) @(negedge clk);
        chk("fair_ack_count", ack_total - a0, 4);
        chk("fair_idle", gnt, '0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares the single I2C master (write/read strobe interface, 32-bit din/dout) between NUM_REQ register-access clients, e.g. the boot config sequencer, the runtime exposure/gain controller and the debug register port.
- Each client issues one 16-bit-address register transaction at a time. The arbiter grants round-robin, drives the master, and returns a one-cycle ack with status and read data.
- Sits between the clients and the I2C master inside the camera control subsystem.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DATA_WIDTH, 32, master din/dout width
TIMEOUT_CYC, 200000, cycles allowed per transaction before abort (4 ms at 50 MHz)
DEV_ADDR, 8'hC0, 8-bit write address of the sensor; read address = DEV_ADDR|1

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req  in  NUM_REQ  per-client request level
i_rnw  in  NUM_REQ  1=read, 0=write
i_addr  in  NUM_REQ*16  register address per client, client k at [16k+15:16k]
i_wdata  in  NUM_REQ*8  write data per client
o_gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
o_ack  out  NUM_REQ  one-cycle completion pulse
o_err  out  1  valid with ack: NACK, arbitration loss or timeout
o_rdata  out  8  valid with ack for reads, else 0
o_i2c_slave_addr  out  8  to master
o_mst_command_byte  out  8  address high byte
o_mst_num_bytes  out  8  3 for write, 1 for read
o_mst_din  out  DATA_WIDTH  {zeros, wdata, addr[7:0]} for write; {zeros, addr[7:0]} for read
o_mst_write  out  1  write strobe
o_mst_read  out  1  read strobe
o_i2c_soft_rst  out  1  one-cycle pulse on timeout
o_i2c_arb_lost_clr  out  1  one-cycle pulse after arbitration loss
i_i2c_busy  in  1  master busy
i_mst_write_done  in  1  write complete
i_mst_data_out_valid  in  1  read data valid
i_mst_data_out  in  DATA_WIDTH  read data; byte [7:0] used
i_i2c_rxak  in  1  1 = NACK received
i_i2c_arb_lost  in  1  arbitration lost

Behaviour:
- Reset: state IDLE; all outputs 0; rr pointer = NUM_REQ-1, so client 0 wins the first arbitration.
- IDLE
  - If any i_req is high, pick the first requester after the pointer, wrapping around.
  - Latch rnw/addr/wdata for that client, set o_gnt, go ISSUE.
  - Fields are latched here; later input changes are ignored.
- ISSUE
  - Drive the master fields from the latched values; hold o_mst_write or o_mst_read high.
  - On i_i2c_busy=1: drop the strobe the same cycle (combinational from state), go WAIT.
- WAIT
  - Write: complete when i_mst_write_done=1 and i_i2c_busy=0.
  - Read: capture i_mst_data_out[7:0] on i_mst_data_out_valid; complete when busy=0 after valid.
  - Go RESP on completion.
- RESP
  - o_ack[g]=1 for one cycle; o_err = rxak | arb_lost sampled at completion; o_rdata shown.
  - Pulse o_i2c_arb_lost_clr if arb_lost.
  - Clear o_gnt, pointer = g, go IDLE. Next arbitration happens the cycle after RESP.
- Timeout counter
  - Cleared when leaving IDLE; counts in ISSUE and WAIT.
  - At TIMEOUT_CYC-1: go RESP with o_err=1 and o_rdata=0, and pulse o_i2c_soft_rst in the RESP cycle.
- Client drops i_req mid-transaction: the transaction still completes and ack is still pulsed.
- A client may re-request in the cycle after its ack. It is served only after the other pending clients (fairness).
- Simultaneous requests are resolved only by the pointer; no fixed priority.
- Reset mid-transaction: immediate return to IDLE with outputs 0. No ack is issued.
- Ack-to-next-grant minimum latency: 2 cycles (RESP→IDLE→ISSUE).

Optional Feature:
- I2C_ARB_RETRY_EN defined:
  - A NACK (rxak) result re-enters ISSUE up to 2 more times, with the same grant and a fresh timeout.
  - o_err is raised only after the third NACK.
  - arb_lost and timeout are never retried.
- Undefined: no retry; the first NACK gives an error ack.

Decomposition:
- Package i2c_ctrl_pkg:
  - arbiter state enum;
  - reg_access_t struct {rnw, addr[15:0], wdata[7:0]};
  - DEV_ADDR default and R/W byte-count constants;
  - also reused by the config sequencer.
- Sub-module rr_arbiter #(N): combinational pointer-based one-hot pick, plus the registered pointer update on an enable input.

Test Plan:
- Client 1 only, write 0x3501=0x2A:
  - o_gnt=3'b010;
  - master sees slave 0xC0, cmd 0x35, num 3, din 0x00002A01;
  - ack[1] with err=0.
- Clients 0,1,2 request simultaneously from reset, all holding req:
  - grants go 0,1,2,0;
  - exactly one ack per transaction;
  - no gap over 2 cycles between RESP and next ISSUE.
- Client 2 reads 0x300A; model returns 0x92:
  - slave 0xC1, num 1;
  - ack[2] with o_rdata=0x92, err=0.
- Model NACKs a write:
  - without the macro: ack with err=1 after one attempt;
  - with I2C_ARB_RETRY_EN: three strobes, then ack with err=1.
- Model never asserts busy: at TIMEOUT_CYC, ack with err=1, a soft_rst pulse, and the next client is granted.
- Assert i_rst while in WAIT: next cycle all outputs 0 and no ack; the following request from client 0 is granted first.
